// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and per-stage hold/flush controls exchanged between the
// pipeline datapath (master) and the hazard sequencer (slave).
interface pipe_hazard_ctrl_if;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic [4:0]  rt_ex;
    logic        memread_ex;
    logic        branch_taken_ex;
    logic        mem_req_mem;
    logic        mem_ack;
    logic        pc_hold;
    logic        ifid_hold;
    logic        idex_hold;
    logic        exmem_hold;
    logic        ifid_flush;
    logic        idex_flush;
    logic        timeout_err;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output rs_id, rt_id, rt_ex, memread_ex, branch_taken_ex, mem_req_mem, mem_ack,
        input  pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush,
               timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_id, rt_id, rt_ex, memread_ex, branch_taken_ex, mem_req_mem, mem_ack,
        output pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush,
               timeout_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer merging load-use, taken-branch and memory-wait hazards.
// Optional statistics counters are built only when HAZ_STATS_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(MEM_WAIT_MAX);
    localparam logic [CNT_W-1:0] WAIT_ONE_C = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             timeout_err_r;
    logic             lu_s;
    logic             mw_s;
    logic [3:0]       hold_s;   // {pc, ifid, idex, exmem}
    logic [1:0]       flush_s;  // {ifid, idex}

    assign lu_s = hz.memread_ex && (hz.rt_ex != 5'd0) &&
                  ((hz.rt_ex == hz.rs_id) || (hz.rt_ex == hz.rt_id));
    assign mw_s = hz.mem_req_mem && !hz.mem_ack;

    // Zero-latency decode of hold/flush controls from state and hazard inputs
    always_comb begin
        hold_s  = 4'b0000;
        flush_s = 2'b00;
        case (state_r)
            ST_RUN: begin
                if (mw_s) begin
                    hold_s = 4'b1111;
                end else if (hz.branch_taken_ex) begin
                    flush_s = 2'b11;
                end else if (lu_s) begin
                    // idex is flushed, not held: the bubble replaces the dependent op
                    hold_s  = 4'b1100;
                    flush_s = 2'b01;
                end else begin
                    hold_s = 4'b0000;
                end
            end
            ST_MEM_WAIT: begin
                if (!hz.mem_ack) begin
                    hold_s = 4'b1111;
                end else begin
                    hold_s = 4'b0000;
                end
            end
            ST_ERR:  hold_s = 4'b1111;
            default: hold_s = 4'b1111;
        endcase
    end

    assign hz.pc_hold     = hold_s[3];
    assign hz.ifid_hold   = hold_s[2];
    assign hz.idex_hold   = hold_s[1];
    assign hz.exmem_hold  = hold_s[0];
    assign hz.ifid_flush  = flush_s[1];
    assign hz.idex_flush  = flush_s[0];
    assign hz.timeout_err = timeout_err_r;

    // Memory-wait state machine with bounded wait counter and sticky timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mw_s) begin
                        state_r    <= ST_MEM_WAIT;
                        wait_cnt_r <= WAIT_ONE_C;
                    end
                end
                ST_MEM_WAIT: begin
                    if (hz.mem_ack) begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= '0;
                    end else if (wait_cnt_r == WAIT_MAX_C) begin
                        state_r       <= ST_ERR;
                        timeout_err_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE_C;
                    end
                end
                ST_ERR: begin
                    state_r       <= ST_ERR;
                    timeout_err_r <= 1'b1;
                end
                default: begin
                    // An illegal encoding is treated as a fault and locks the pipeline
                    state_r       <= ST_ERR;
                    timeout_err_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;
    logic        run_s;

    assign run_s = (state_r == ST_RUN) && !mw_s;

    // Saturating statistics for branch flushes and load-use stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (run_s && hz.branch_taken_ex && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end
            if (run_s && !hz.branch_taken_ex && lu_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_r;
    assign hz.flush_cnt = flush_cnt_r;
`else
    assign hz.stall_cnt = 16'd0;
    assign hz.flush_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int MAXW = 4;

    typedef struct packed {
        logic       mr;
        logic [4:0] rte;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       req;
        logic       ack;
    } stim_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Model: holds seen in the current memory wait (0 = not waiting), error lock, counts
    int   m_holds;
    bit   m_err;
    int   m_stall;
    int   m_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.MEM_WAIT_MAX(MAXW), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    function automatic stim_t mk(input logic mr, input logic [4:0] rte, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic br, input logic req,
                                 input logic ack);
        stim_t s;
        s.mr = mr; s.rte = rte; s.rs = rs; s.rt = rt; s.br = br; s.req = req; s.ack = ack;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        hz.memread_ex      = s.mr;
        hz.rt_ex           = s.rte;
        hz.rs_id           = s.rs;
        hz.rt_id           = s.rt;
        hz.branch_taken_ex = s.br;
        hz.mem_req_mem     = s.req;
        hz.mem_ack         = s.ack;
    endtask

    function automatic bit load_use();
        return hz.memread_ex && (hz.rt_ex != 5'd0) &&
               ((hz.rt_ex == hz.rs_id) || (hz.rt_ex == hz.rt_id));
    endfunction

    // Expected {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush}
    function automatic logic [5:0] exp_ctrl();
        if (m_err)                          return 6'b111100;
        if (m_holds > 0)                    return hz.mem_ack ? 6'b000000 : 6'b111100;
        if (hz.mem_req_mem && !hz.mem_ack)  return 6'b111100;
        if (hz.branch_taken_ex)             return 6'b000011;
        if (load_use())                     return 6'b110001;
        return 6'b000000;
    endfunction

    function automatic logic [38:0] exp_all();
        logic [15:0] st;
        logic [15:0] fl;
`ifdef HAZ_STATS_EN
        st = (m_stall > 65535) ? 16'hFFFF : 16'(m_stall);
        fl = (m_flush > 65535) ? 16'hFFFF : 16'(m_flush);
`else
        st = 16'd0;
        fl = 16'd0;
`endif
        return {exp_ctrl(), m_err, st, fl};
    endfunction

    function automatic logic [38:0] obs_all();
        return {hz.pc_hold, hz.ifid_hold, hz.idex_hold, hz.exmem_hold, hz.ifid_flush,
                hz.idex_flush, hz.timeout_err, hz.stall_cnt, hz.flush_cnt};
    endfunction

    // Applies the spec rules at a clock edge using the inputs present during the cycle
    task automatic model_edge();
        if (m_err) begin
            m_err = 1'b1;
        end else if (m_holds > 0) begin
            if (hz.mem_ack) m_holds = 0;
            else begin
                m_holds = m_holds + 1;
                if (m_holds == MAXW + 1) m_err = 1'b1;
            end
        end else if (hz.mem_req_mem && !hz.mem_ack) begin
            m_holds = 1;
        end else if (hz.branch_taken_ex) begin
            m_flush = m_flush + 1;
        end else if (load_use()) begin
            m_stall = m_stall + 1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        drive(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        rst_n   = 1'b0;
        m_holds = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        #2;
        checks++;
        if (obs_all() !== 39'd0) begin
            errors++;
            $display("FAIL reset_async got=%h exp=0", obs_all());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        settle();
        checks++;
        if (obs_all() !== exp_all()) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs_all(), exp_all());
        end
        advance();
    endtask

    task automatic test_load_use();
        stim_t seq[$];
        seq = '{mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0),
                mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0),
                mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0),
                mk(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0),
                mk(1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0),
                mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0)};
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            settle();
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL load_use step=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            advance();
        end
    endtask

    task automatic test_branch_lu();
        stim_t seq[$];
        seq = '{mk(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0),
                mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0)};
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            settle();
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL branch_lu step=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            advance();
        end
    endtask

    task automatic test_mem_wait();
        stim_t seq[$];
        int    holds = 0;
        seq = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1),
                mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0),
                mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0),
                mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0),
                mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1),
                mk(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0)};
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            settle();
            if (hz.exmem_hold === 1'b1) holds++;
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL mem_wait step=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            advance();
        end
        checks++;
        if (holds !== 3) begin
            errors++;
            $display("FAIL mem_wait_len got=%0d exp=3", holds);
        end
    endtask

    task automatic test_timeout();
        int pre_err_holds = 0;
        for (int i = 0; i < 9; i++) begin
            drive(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
            settle();
            if (hz.exmem_hold === 1'b1 && hz.timeout_err === 1'b0) pre_err_holds++;
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL timeout step=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            advance();
        end
        checks++;
        if (pre_err_holds !== MAXW + 1 || hz.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_len got=%0d/%b exp=%0d/1", pre_err_holds, hz.timeout_err, MAXW + 1);
        end
        apply_reset();
        // reset in the middle of a fresh wait
        for (int i = 0; i < 2; i++) begin
            drive(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
            advance();
        end
        apply_reset();
    endtask

    task automatic test_deferred_branch();
        stim_t seq[$];
        int    flush_at = -1;
        seq = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0),
                mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0),
                mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1),
                mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0),
                mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0)};
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            settle();
            if (hz.ifid_flush === 1'b1 && flush_at < 0) flush_at = i;
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL deferred_br step=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            advance();
        end
        checks++;
        if (flush_at !== 3) begin
            errors++;
            $display("FAIL deferred_br_cycle got=%0d exp=3", flush_at);
        end
    endtask

    task automatic test_random();
        int err_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_err) err_cycles++;
            if (err_cycles > 3) begin
                err_cycles = 0;
                apply_reset();
            end
            drive(mk(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1))));
            settle();
            checks++;
            if (obs_all() !== exp_all()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_deferred_branch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
